md_sequencer: RTL and testbench
===============================

MD_SEQUENCER -- requirements
Module: md_sequencer

Interface
REQ-001 Parameter STEPS, default 32, number of iterative multiply/divide step cycles (legal range 2..64).
REQ-002 clk  input  1  sole clock; all state updates on posedge clk.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-004 op_valid  input  1  requester presents an operation this cycle.
REQ-005 op_funct  input  6  function code: AND 36, OR 37, ADD 32, SUB 34, SLT 42, SRL 2, MULTU 25, DIVU 27, MFHI 16, MFLO 18.
REQ-006 op_ready  output  1  sequencer accepts op_funct this cycle; transfer occurs when op_valid && op_ready.
REQ-007 div_zero  input  1  divisor-is-zero indication from the datapath, sampled only in LOAD.
REQ-008 alu_sel  output  6  registered function code driven to the ALU/shifter/output mux.
REQ-009 md_load  output  1  load operands into the multiply/divide unit.
REQ-010 md_step  output  1  advance the multiply/divide unit by one iteration.
REQ-011 md_is_div  output  1  1 = divide, 0 = multiply; held stable from LOAD through WRITE.
REQ-012 hilo_we  output  1  write the multiply/divide result into the HI/LO registers.
REQ-013 busy  output  1  a multiply/divide operation is in flight.
REQ-014 done  output  1  one-cycle pulse coincident with hilo_we.
REQ-015 dz_flag  output  1  one-cycle pulse with done when the DIVU was aborted for a zero divisor.
REQ-016 illegal  output  1  one-cycle pulse the cycle after an unrecognised op_funct is accepted.

Function
REQ-017 States SHALL be IDLE, LOAD, RUN and WRITE; op_ready SHALL be 1 only in IDLE.
REQ-018 In IDLE, an accepted ALU op (AND, OR, ADD, SUB, SLT, SRL, MFHI, MFLO) SHALL drive alu_sel = op_funct for exactly the next cycle, with state remaining IDLE.
REQ-019 alu_sel SHALL be 6'b000000 in every cycle not covered by REQ-018 or REQ-023.
REQ-020 An accepted MULTU or DIVU in cycle T SHALL give LOAD in T+1 (md_load=1, busy=1, md_is_div set), then RUN in T+2..T+1+STEPS (md_step=1 each cycle), then WRITE in T+2+STEPS, then IDLE in T+3+STEPS.
REQ-021 The step counter SHALL be cleared in LOAD, SHALL increment once per RUN cycle, and SHALL leave RUN when it reaches STEPS-1; width is ceil(log2(STEPS))+1 bits with no wrap.
REQ-022 In LOAD, if md_is_div=1 and div_zero=1, the sequencer SHALL skip RUN and enter WRITE in T+2, and SHALL assert dz_flag in that WRITE cycle.
REQ-023 In WRITE, hilo_we=1, done=1 and alu_sel=6'b111111 (HI/LO write select) SHALL be asserted for exactly one cycle.
REQ-024 busy SHALL be 1 in LOAD, RUN and WRITE and 0 in IDLE; MFHI/MFLO issued while busy SHALL stall via op_ready=0 until IDLE.
REQ-025 An unrecognised op_funct SHALL be accepted in IDLE, SHALL leave alu_sel=0, and SHALL pulse illegal in the following cycle.
REQ-026 While op_valid=0, op_funct SHALL be ignored, including any changes to it while busy.
REQ-027 md_load, md_step and hilo_we SHALL be mutually exclusive in every cycle.

Reset
REQ-028 On reset=1 at posedge clk: state=IDLE, counter=0; alu_sel=0; md_load, md_step, md_is_div, hilo_we, busy, done, dz_flag and illegal all 0.
REQ-029 On reset=1 at posedge clk, op_ready SHALL be 0 for that cycle and 1 afterwards.
REQ-030 A reset during LOAD, RUN or WRITE SHALL abort the operation with no hilo_we pulse after the reset edge.
REQ-031 reset SHALL take priority over a simultaneous op_valid.

Structure
REQ-032 The funct-code constants, the 6'b111111 HI/LO select code and the state encoding SHALL live in a shared alu_pkg package used by the ALU, the shifter and the divider control.
REQ-033 The step counter SHALL be a sub-module md_step_counter with clear, enable and terminal-count ports; everything else is a single FSM in md_sequencer.

Verification
REQ-034 ADD (32) accepted at T -> alu_sel=32 at T+1 only, busy stays 0, op_ready stays 1.
REQ-035 MULTU accepted at T, STEPS=32 -> md_load at T+1; md_step at T+2..T+33 (32 pulses); hilo_we, done and alu_sel=63 at T+34; op_ready=1 at T+35.
REQ-036 DIVU with div_zero=1 during LOAD -> hilo_we, done and dz_flag at T+2; zero md_step pulses.
REQ-037 MFHI held valid from T+3 of a MULTU -> op_ready=0 until T+35; MFHI accepted at T+35; alu_sel=16 at T+36.
REQ-038 reset asserted at T+10 of a DIVU -> all outputs 0 from T+11, no hilo_we; a new MULTU is accepted at T+12 and completes normally.
REQ-039 op_funct=6'b001111 accepted -> illegal pulses for one cycle, alu_sel=0, state IDLE.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: funct codes, HI/LO write select and sequencer state encoding shared by the ALU, shifter and divider control.
package alu_pkg;
    typedef logic [5:0] funct_t;
    localparam funct_t F_AND      = 6'd36;
    localparam funct_t F_OR       = 6'd37;
    localparam funct_t F_ADD      = 6'd32;
    localparam funct_t F_SUB      = 6'd34;
    localparam funct_t F_SLT      = 6'd42;
    localparam funct_t F_SRL      = 6'd2;
    localparam funct_t F_MULTU    = 6'd25;
    localparam funct_t F_DIVU     = 6'd27;
    localparam funct_t F_MFHI     = 6'd16;
    localparam funct_t F_MFLO     = 6'd18;
    localparam funct_t F_HILO_SEL = 6'b111111;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;
    localparam logic [1:0] ST_WRITE = 2'd3;
    function automatic logic is_alu_op(input funct_t f);
        return f inside {F_AND, F_OR, F_ADD, F_SUB, F_SLT, F_SRL, F_MFHI, F_MFLO};
    endfunction
    function automatic logic is_md_op(input funct_t f);
        return f inside {F_MULTU, F_DIVU};
    endfunction
endpackage

// File: rtl/md_sequencer_if.sv
// md_sequencer_if: op handshake plus datapath control bundle between requester/datapath and the sequencer.
interface md_sequencer_if;
    import alu_pkg::*;
    logic   op_valid;
    funct_t op_funct;
    logic   op_ready;
    logic   div_zero;
    funct_t alu_sel;
    logic   md_load;
    logic   md_step;
    logic   md_is_div;
    logic   hilo_we;
    logic   busy;
    logic   done;
    logic   dz_flag;
    logic   illegal;
    modport master (
        output op_valid, op_funct, div_zero,
        input  op_ready, alu_sel, md_load, md_step, md_is_div, hilo_we, busy, done, dz_flag, illegal
    );
    modport slave (
        input  op_valid, op_funct, div_zero,
        output op_ready, alu_sel, md_load, md_step, md_is_div, hilo_we, busy, done, dz_flag, illegal
    );
endinterface

// File: rtl/md_step_counter.sv
// md_step_counter: iteration counter for multiply/divide, cleared on demand, flags the final step.
module md_step_counter #(
    parameter int STEPS = 32
) (
    input  logic clk,
    input  logic clear,
    input  logic enable,
    output logic tc
);
    localparam int CW = $clog2(STEPS) + 1;
    logic [CW-1:0] cnt_q, cnt_d;
    always_comb cnt_d = clear ? '0 : enable ? cnt_q + CW'(1) : cnt_q;
    always_ff @(posedge clk) cnt_q <= cnt_d;
    assign tc = cnt_q == CW'(STEPS - 1);
endmodule

// File: rtl/md_sequencer.sv
// md_sequencer: issues ALU selects and sequences iterative MULTU/DIVU through LOAD, RUN and WRITE.
module md_sequencer
    import alu_pkg::*;
#(
    parameter int STEPS = 32
) (
    input logic clk,
    input logic reset,
    md_sequencer_if.slave bus
);
    logic [1:0] state_q, state_d;
    funct_t sel_q, sel_d;
    logic div_q, div_d, dz_q, dz_d, ill_q, ill_d;
    logic accept, is_alu, is_md, tc;
    assign bus.op_ready = state_q == ST_IDLE && !reset;
    assign accept = bus.op_valid && bus.op_ready;
    assign is_alu = is_alu_op(bus.op_funct);
    assign is_md  = is_md_op(bus.op_funct);
    always_comb begin
        state_d = state_q == ST_IDLE ? ((accept && is_md) ? ST_LOAD : ST_IDLE)
                : state_q == ST_LOAD ? ((div_q && bus.div_zero) ? ST_WRITE : ST_RUN)
                : state_q == ST_RUN  ? (tc ? ST_WRITE : ST_RUN)
                : ST_IDLE;
        sel_d = (accept && is_alu) ? bus.op_funct : '0;
        div_d = (accept && is_md) ? bus.op_funct == F_DIVU : state_q == ST_WRITE ? 1'b0 : div_q;
        // zero-divisor verdict is latched in LOAD and only shown in WRITE
        dz_d  = state_q == ST_LOAD ? div_q && bus.div_zero : dz_q;
        ill_d = accept && !is_alu && !is_md;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            div_q   <= 1'b0;
            dz_q    <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            div_q   <= div_d;
            dz_q    <= dz_d;
            ill_q   <= ill_d;
        end
    end
    md_step_counter #(.STEPS(STEPS)) u_cnt (
        .clk   (clk),
        .clear (reset || state_q == ST_LOAD),
        .enable(state_q == ST_RUN),
        .tc    (tc)
    );
    assign bus.alu_sel   = state_q == ST_WRITE ? F_HILO_SEL : sel_q;
    assign bus.md_load   = state_q == ST_LOAD;
    assign bus.md_step   = state_q == ST_RUN;
    assign bus.md_is_div = div_q;
    assign bus.hilo_we   = state_q == ST_WRITE;
    assign bus.done      = state_q == ST_WRITE;
    assign bus.dz_flag   = state_q == ST_WRITE && dz_q;
    assign bus.busy      = state_q != ST_IDLE;
    assign bus.illegal   = ill_q;
endmodule

// File: tb/tb_md_sequencer.sv
// tb_md_sequencer: scoreboard bench; stimulus pushes expected output events, a negedge monitor pops and compares.
module tb_md_sequencer;
    localparam int STEPS = 32;
    logic clk = 1'b0;
    logic reset = 1'b1;
    md_sequencer_if bus();
    md_sequencer #(.STEPS(STEPS)) dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;
    typedef struct {
        int cyc; logic [5:0] sel; bit we; bit dz; bit ill; bit md; bit div; int load_cyc; int steps;
    } rec_t;
    rec_t q[$];
    int errors = 0, checks = 0;
    int busy_from = 0, busy_until = 0;
    bit prev_rst = 1'b0, plan_dz = 1'b0;
    int step_cnt = 0;
    int n_ex;
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask
    function automatic bit is_md_code(input logic [5:0] f);
        return f == 6'd25 || f == 6'd27;
    endfunction
    function automatic bit is_alu_code(input logic [5:0] f);
        logic [5:0] alu_codes [8] = '{6'd36, 6'd37, 6'd32, 6'd34, 6'd42, 6'd2, 6'd16, 6'd18};
        foreach (alu_codes[i]) if (alu_codes[i] == f) return 1'b1;
        return 1'b0;
    endfunction
    always @(negedge clk) begin
        n_ex = int'(bus.md_load) + int'(bus.md_step) + int'(bus.hilo_we);
        chk("md_exclusive", n_ex <= 1, 1);
        while (q.size() > 0 && q[0].cyc < cyc) begin
            checks++;
            errors++;
            $display("FAIL missing_event: expected at cycle %0d, not seen by cycle %0d", q[0].cyc, cyc);
            void'(q.pop_front());
        end
        if (bus.md_load) begin
            step_cnt = 0;
            chk("md_load_cycle", (q.size() > 0 && q[0].md) ? q[0].load_cyc : -1, cyc);
        end
        if (bus.md_step) begin
            step_cnt++;
            chk("md_step_window", q.size() > 0 && q[0].md && cyc > q[0].load_cyc
                && cyc <= q[0].load_cyc + q[0].steps, 1);
        end
        if ((bus.md_load || bus.md_step || bus.hilo_we) && q.size() > 0 && q[0].md)
            chk("md_is_div", bus.md_is_div, q[0].div);
        if (bus.alu_sel != 0 || bus.hilo_we || bus.done || bus.dz_flag || bus.illegal) begin
            if (q.size() > 0 && q[0].cyc == cyc) begin
                chk("alu_sel", bus.alu_sel, q[0].sel);
                chk("hilo_we", bus.hilo_we, q[0].we);
                chk("done", bus.done, q[0].we);
                chk("dz_flag", bus.dz_flag, q[0].dz);
                chk("illegal", bus.illegal, q[0].ill);
                if (q[0].md) chk("step_count", step_cnt, q[0].steps);
                void'(q.pop_front());
            end else begin
                checks++;
                errors++;
                $display("FAIL unexpected_output at cycle %0d: alu_sel=%0d hilo_we=%0b done=%0b dz=%0b illegal=%0b",
                         cyc, bus.alu_sel, bus.hilo_we, bus.done, bus.dz_flag, bus.illegal);
            end
        end
    end
    task automatic drive(input bit v, input logic [5:0] f, input bit r, input bit dzp, output bit acc);
        bit be;
        rec_t rc;
        @(posedge clk);
        #1;
        reset = r;
        bus.op_valid = v;
        bus.op_funct = v ? f : 6'($urandom);
        bus.div_zero = (cyc == busy_from && busy_until > cyc) ? plan_dz : 1'($urandom);
        @(negedge clk);
        be = cyc >= busy_from && cyc < busy_until;
        chk("op_ready", bus.op_ready, !r && !be);
        chk("busy", bus.busy, be);
        if (prev_rst)
            chk("post_reset_zero", {bus.alu_sel, bus.md_load, bus.md_step, bus.md_is_div, bus.hilo_we,
                                    bus.busy, bus.done, bus.dz_flag, bus.illegal}, 0);
        #1;
        acc = 1'b0;
        if (r) begin
            for (int i = q.size() - 1; i >= 0; i--) if (q[i].cyc > cyc) q.delete(i);
            if (busy_until > cyc + 1) busy_until = cyc + 1;
        end else if (v && !be) begin
            acc = 1'b1;
            rc = '{default: 0};
            rc.cyc = cyc + 1;
            if (is_md_code(f)) begin
                rc.md = 1'b1;
                rc.div = f == 6'd27;
                rc.load_cyc = cyc + 1;
                rc.dz = rc.div && dzp;
                rc.steps = rc.dz ? 0 : STEPS;
                rc.cyc = cyc + 2 + rc.steps;
                rc.sel = 6'd63;
                rc.we = 1'b1;
                busy_from = cyc + 1;
                busy_until = rc.cyc + 1;
                plan_dz = dzp;
            end else if (is_alu_code(f)) rc.sel = f;
            else rc.ill = 1'b1;
            q.push_back(rc);
        end
        prev_rst = r;
    endtask
    bit a, pv, rr;
    logic [5:0] pf;
    logic [5:0] codes [12] = '{6'd36, 6'd37, 6'd32, 6'd34, 6'd42, 6'd2, 6'd25, 6'd27, 6'd16, 6'd18, 6'd15, 6'd63};
    initial begin
        bus.op_valid = 1'b0;
        bus.op_funct = '0;
        bus.div_zero = 1'b0;
        repeat (3) drive(0, 0, 1, 0, a);
        drive(0, 0, 0, 0, a);
        drive(1, 6'd32, 0, 0, a);
        repeat (2) drive(0, 0, 0, 0, a);
        drive(1, 6'd25, 0, 1, a);
        repeat (2) drive(0, 0, 0, 0, a);
        a = 1'b0;
        for (int i = 0; i < 100 && !a; i++) drive(1, 6'd16, 0, 0, a);
        repeat (2) drive(0, 0, 0, 0, a);
        drive(1, 6'd27, 0, 1, a);
        repeat (4) drive(0, 0, 0, 0, a);
        drive(1, 6'd27, 0, 0, a);
        repeat (9) drive(0, 0, 0, 0, a);
        drive(0, 0, 1, 0, a);
        drive(0, 0, 0, 0, a);
        drive(1, 6'd25, 0, 0, a);
        repeat (STEPS + 4) drive(0, 0, 0, 0, a);
        drive(1, 6'd15, 0, 0, a);
        repeat (2) drive(0, 0, 0, 0, a);
        pv = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            rr = $urandom_range(0, 199) == 0;
            if (!pv && $urandom_range(0, 2) == 0) begin
                pv = 1'b1;
                pf = ($urandom_range(0, 4) == 0) ? 6'($urandom) : codes[$urandom_range(0, 11)];
            end
            drive(pv, pf, rr, 1'($urandom), a);
            if (a) pv = 1'b0;
        end
        repeat (STEPS + 5) drive(0, 0, 0, 0, a);
        chk("queue_drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
